// File: rtl/approx_mul_trunc_pipe.sv
// approx_mul_trunc_pipe
// Pipelined unsigned WxW multiplier whose partial-product rows for x[L-1:0]
// can be dropped per transaction, optionally compensated by a constant BIAS.
// Each result also carries the signed error exact(x*y) - approx.
// Valid/ready on both sides; each of the STAGES register stages has its own
// valid bit, so bubbles collapse while the output is stalled.

module approx_mul_trunc_pipe #(
  parameter int              W      = 32,
  parameter int              L      = 10,
  parameter int              STAGES = 2,
  parameter logic [2*W-1:0]  BIAS   = '0,
  parameter bit              ERR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   z,
  output logic [2*W:0]     err,
  output logic [31:0]      ops_cnt
);

  // Rows of x below L are the ones a truncated multiply throws away.
  localparam logic [W-1:0] LO_MASK = W'((65'd1 << L) - 65'd1);

  localparam logic [1:0] MODE_TRUNC = 2'd1;
  localparam logic [1:0] MODE_BIAS  = 2'd2;

  // ---------------------------------------------------------------------------
  // Arithmetic front end. The exact product is split into the kept rows
  // (trunc_p) and the dropped rows (low_p); the exact result is their sum and
  // the error of a truncated result is simply the dropped part, minus BIAS.
  // ---------------------------------------------------------------------------
  logic [W-1:0]   x_hi;
  logic [W-1:0]   x_lo;
  logic [2*W-1:0] trunc_p;
  logic [2*W-1:0] low_p;
  logic [2*W-1:0] exact_p;
  logic [2*W:0]   approx_p;
  logic [2*W:0]   err_p;
  logic           accept;

  assign x_hi    = x & ~LO_MASK;
  assign x_lo    = x &  LO_MASK;
  assign trunc_p = {{W{1'b0}}, y} * {{W{1'b0}}, x_hi};
  assign low_p   = {{W{1'b0}}, y} * {{W{1'b0}}, x_lo};
  // Cannot overflow: the sum is x*y, which fits in 2W bits.
  assign exact_p = trunc_p + low_p;

  // Select the approximate result for the requested mode (2W+1 bits wide).
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so a
    // missing case arm can never infer a latch.
    approx_p = {1'b0, exact_p};
    case (mode)
      MODE_TRUNC: approx_p = {1'b0, trunc_p};
      MODE_BIAS:  approx_p = {1'b0, trunc_p} + {1'b0, BIAS};
      default:    approx_p = {1'b0, exact_p};
    endcase
  end

  if (ERR_EN) begin : g_err
    // Error = exact - approx = dropped rows (minus BIAS in the biased mode).
    always_comb begin
      err_p = '0;
      case (mode)
        MODE_TRUNC: err_p = {1'b0, low_p};
        MODE_BIAS:  err_p = {1'b0, low_p} - {1'b0, BIAS};
        default:    err_p = '0;
      endcase
    end
  end else begin : g_noerr
    assign err_p = '0;
  end

  // ---------------------------------------------------------------------------
  // Pipeline control. A stage advances when it holds data and its successor
  // is empty or advancing; the last stage's successor is the consumer.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] ld;
  logic [2*W-1:0]    z_q   [STAGES];
  logic [2*W:0]      err_q [STAGES];
  logic [2*W-1:0]    z_src [STAGES];
  logic [2*W:0]      e_src [STAGES];

  // Walk the valid chain from the output back to the input.
  always_comb begin
    logic nxt_free;
    nxt_free = out_ready;
    adv      = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i]   = v_q[i] & nxt_free;
      nxt_free = ~v_q[i] | (v_q[i] & nxt_free);
    end
    in_ready = nxt_free;
  end

  assign accept = in_valid & in_ready;

  // Each stage loads from its predecessor (stage 0 from the arithmetic).
  always_comb begin
    z_src[0] = approx_p[2*W-1:0];
    e_src[0] = err_p;
    ld[0]    = accept;
    for (int i = 1; i < STAGES; i++) begin
      z_src[i] = z_q[i-1];
      e_src[i] = err_q[i-1];
      ld[i]    = adv[i-1];
    end
  end

  // Stage registers: load on upstream move, empty when draining downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset along with the valids because z
      // and err must read 0 straight out of reset, not merely be ignored.
      for (int i = 0; i < STAGES; i++) begin
        v_q[i]   <= 1'b0;
        z_q[i]   <= '0;
        err_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments, so every stage samples its
      // predecessor's pre-edge value regardless of loop order.
      for (int i = 0; i < STAGES; i++) begin
        if (ld[i]) begin
          v_q[i]   <= 1'b1;
          z_q[i]   <= z_src[i];
          err_q[i] <= e_src[i];
        end else if (adv[i]) begin
          v_q[i]   <= 1'b0;
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign z         = z_q[STAGES-1];
  assign err       = err_q[STAGES-1];

  // Count accepted transactions; wraps naturally at 2^32.
  logic [31:0] ops_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt_q <= '0;
    end else if (accept) begin
      ops_cnt_q <= ops_cnt_q + 32'd1;
    end
  end

  assign ops_cnt = ops_cnt_q;

endmodule

// File: tb/tb_approx_mul_trunc_pipe.sv
// tb_approx_mul_trunc_pipe
// Scoreboard bench: the expected result of every accepted operand pair is
// pushed when the handshake is seen and compared when the DUT hands it out.

module tb_approx_mul_trunc_pipe;

  localparam int          W      = 32;
  localparam int          L      = 10;
  localparam int          STAGES = 2;
  localparam logic [63:0] BIAS   = 64'h200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] z;
  logic [64:0] err;
  logic [31:0] ops_cnt;

  approx_mul_trunc_pipe #(
    .W(W), .L(L), .STAGES(STAGES), .BIAS(BIAS), .ERR_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .err(err), .ops_cnt(ops_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] z;
    logic [64:0] e;
  } exp_t;

  exp_t        sb[$];
  exp_t        head;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  logic [31:0] n_acc = '0;
  bit          rand_rdy = 1'b0;
  bit          hold = 1'b0;
  logic [63:0] hold_z;
  logic [64:0] hold_e;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Golden model written straight from the arithmetic definition.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    logic [64:0] ex;
    logic [64:0] tr;
    logic [64:0] ap;
    logic [31:0] ah;
    exp_t        r;
    ex = 65'(a) * 65'(b);
    ah = a >> L;
    tr = (65'(ah) * 65'(b)) << L;
    case (m)
      2'd1:    ap = tr;
      2'd2:    ap = tr + 65'(BIAS);
      default: ap = ex;
    endcase
    r.z = ap[63:0];
    r.e = ex - ap;
    return r;
  endfunction

  // Output monitor: compare on handshake, check stability while stalled.
  always @(negedge clk) begin
    if (hold && rst_n) begin
      check("hold_valid", 128'(out_valid), 128'(1'b1));
      check("hold_z", 128'(z), 128'(hold_z));
      check("hold_err", 128'(err), 128'(hold_e));
    end
    hold = 1'b0;
    if (rst_n && out_valid) begin
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 128'(out_valid), 128'(1'b0));
        end else begin
          head = sb.pop_front();
          check("z", 128'(z), 128'(head.z));
          check("err", 128'(err), 128'(head.e));
          n_out++;
        end
      end else begin
        hold   = 1'b1;
        hold_z = z;
        hold_e = err;
      end
    end
  end

  // Random consumer backpressure for the bulk phase.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    sb.push_back(model(a, b, m));
    n_acc = n_acc + 32'd1;
  endtask

  // Present one operand pair and hold it until accepted (bounded).
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    bit got;
    got      = 1'b0;
    x        = a;
    y        = b;
    mode     = m;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push(a, b, m);
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("send_timeout", 128'(got), 128'(1'b1));
    in_valid = 1'b0;
  endtask

  // Send one pair, wait for its result and compare against literal values.
  task automatic one_shot(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] m, input logic [63:0] ez, input logic [64:0] ee);
    bit seen;
    seen = 1'b0;
    send(a, b, m);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_seen"}, 128'(seen), 128'(1'b1));
    check({tag, "_z"}, 128'(z), 128'(ez));
    check({tag, "_err"}, 128'(err), 128'(ee));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
    check("drain_left", 128'(sb.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sx [8];
  logic [31:0] sy [8];
  logic [1:0]  sm [8];

  initial begin
    int acc;
    int idx;
    int out_base;
    logic [31:0] ra;
    logic [31:0] rb;

    // ---- reset state ----
    #2;
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_z", 128'(z), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_ops_cnt", 128'(ops_cnt), 128'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));

    // ---- latency: result exactly STAGES cycles after acceptance ----
    out_ready = 1'b1;
    send(32'h400, 32'd3, 2'd1);
    mode = 2'd0;                       // late mode change must not matter
    check("lat_1", 128'(out_valid), 128'(1'b0));
    @(posedge clk);
    #1;
    check("lat_2", 128'(out_valid), 128'(1'b1));
    check("lat_z", 128'(z), 128'(64'hC00));
    check("lat_err", 128'(err), 128'(0));
    drain();

    // ---- directed arithmetic corners ----
    one_shot("m1_lowrows", 32'h3FF, 32'hFFFF_FFFF, 2'd1, 64'h0, 65'h3FE_FFFF_FC01);
    one_shot("m0_exact", 32'h3FF, 32'hFFFF_FFFF, 2'd0, 64'h3FE_FFFF_FC01, 65'h0);
    one_shot("m2_bias", 32'h7FF, 32'd1, 2'd2, 64'h600, 65'h1FF);
    one_shot("m2_neg_err", 32'h400, 32'd1, 2'd2, 64'h600, 65'h1_FFFF_FFFF_FFFF_FE00);
    one_shot("m2_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2,
             64'hFFFF_FBFF_0000_0600, 65'h3FE_FFFF_FA01);
    one_shot("m3_exact", 32'd5, 32'd7, 2'd3, 64'd35, 65'h0);
    drain();
    check("ops_cnt_directed", 128'(ops_cnt), 128'(n_acc));

    // ---- stall: capacity STAGES, then in_ready low; order preserved ----
    for (int i = 0; i < 8; i++) begin
      sx[i] = $urandom();
      sy[i] = $urandom();
      sm[i] = 2'($urandom_range(0, 3));
    end
    out_base = n_out;
    acc = 0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 5);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        x    = sx[idx];
        y    = sy[idx];
        mode = sm[idx];
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        push(sx[idx], sy[idx], sm[idx]);
        idx++;
        if (c < 5) acc++;
      end
      if (c == 4) check("stall_in_ready", 128'(in_ready), 128'(1'b0));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stall_accepts", 128'(acc), 128'(STAGES));
    drain();
    check("stall_results", 128'(n_out - out_base), 128'(8));

    // ---- reset with two transactions in flight ----
    out_ready = 1'b0;
    send($urandom(), $urandom(), 2'd1);
    send($urandom(), $urandom(), 2'd2);
    check("pre_rst_valid", 128'(out_valid), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    hold  = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    check("midrst_z", 128'(z), 128'(0));
    check("midrst_ops_cnt", 128'(ops_cnt), 128'(0));
    sb.delete();
    n_acc = '0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_stale", 128'(out_valid), 128'(1'b0));
    check("post_rst_ops_cnt", 128'(ops_cnt), 128'(0));

    // ---- ops_cnt wrap ----
    force dut.ops_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.ops_cnt_q;
    n_acc = 32'hFFFF_FFFE;
    send(32'd9, 32'd9, 2'd0);
    check("wrap_ffffffff", 128'(ops_cnt), 128'(32'hFFFF_FFFF));
    send(32'd10, 32'd10, 2'd1);
    check("wrap_zero", 128'(ops_cnt), 128'(n_acc));
    drain();

    // ---- bulk random traffic against the model ----
    rand_rdy = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom();
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = $urandom() & 32'h3FF;
        default: ra = $urandom_range(0, 2047);
      endcase
      rb = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
      send(ra, rb, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    #2 out_ready = 1'b1;
    drain();
    check("ops_cnt_random", 128'(ops_cnt), 128'(n_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
